// File: rtl/float8_mul_arbiter.sv
// Two-requester round-robin front end sharing one float8 multiplier.
// Float8 layout: sign[7], exponent[6:4] biased by 7, fraction[3:0] with implicit leading 1.

module float8_multiplication (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic              sign;
  logic [9:0]        mant;
  logic              norm;
  logic [3:0]        frac;
  logic signed [5:0] exp_sum;

  // Fraction is truncated; out-of-range exponents flush to signed zero or saturate to max.
  always_comb begin
    sign    = a[7] ^ b[7];
    mant    = {5'b0, 1'b1, a[3:0]} * {5'b0, 1'b1, b[3:0]};
    norm    = mant[9];
    frac    = norm ? mant[8:5] : mant[7:4];
    exp_sum = $signed({3'b0, a[6:4]}) + $signed({3'b0, b[6:4]})
            + $signed({5'b0, norm}) - 6'sd7;
    if (exp_sum < 6'sd0) begin
      p = {sign, 7'h00};
    end else if (exp_sum > 6'sd7) begin
      p = {sign, 7'h7F};
    end else begin
      p = {sign, exp_sum[2:0], frac};
    end
  end
endmodule

module float8_mul_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic             id_q, id_d, last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_valid, grant_id;
  logic [7:0]       mul_p;

  float8_multiplication u_mul (
    .a (a_q),
    .b (b_q),
    .p (mul_p)
  );

  // Under contention the requester not granted last wins; otherwise the lone valid one.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      res_q   <= 8'h00;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = CALC;
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
          id_d    = grant_id;
          last_d  = grant_id;
        end
      end
      CALC: begin
        res_d   = mul_p;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && !rst && grant_valid && !grant_id;
    req1_ready = (state_q == IDLE) && !rst && grant_valid && grant_id;
    rsp_valid  = (state_q == RESP);
    rsp_id     = id_q;
    rsp_data   = res_q;
    op_count   = cnt_q;
  end
endmodule

// File: tb/tb_float8_mul_arbiter.sv
// Directed scoreboard bench for float8_mul_arbiter with an independent real-valued multiplier model.

module tb_float8_mul_arbiter;
  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [7:0]  rsp_data;
  logic [15:0] op_count;
  logic        w_req0_ready, w_req1_ready, w_rsp_valid, w_rsp_id;
  logic [7:0]  w_rsp_data;
  logic [3:0]  op_count4;

  float8_mul_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .op_count(op_count)
  );

  float8_mul_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(w_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(w_req1_ready),
    .rsp_valid(w_rsp_valid), .rsp_id(w_rsp_id), .rsp_data(w_rsp_data), .rsp_ready(rsp_ready),
    .op_count(op_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   gcyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  logic stall_prev = 1'b0, rst_prev = 1'b1, prev_valid = 1'b0, prev_id = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int   cnt_snap;

  function automatic logic [7:0] f8mul(input logic [7:0] a, input logic [7:0] b);
    real  v;
    int   e;
    int   fr;
    logic s;
    s = a[7] ^ b[7];
    v = real'((16 + int'(a[3:0])) * (16 + int'(b[3:0]))) / 256.0;
    e = int'(a[6:4]) + int'(b[6:4]) - 14;
    while (v >= 2.0) begin
      v = v / 2.0;
      e++;
    end
    if (e < -7) return {s, 7'h00};
    if (e > 0) return {s, 7'h7F};
    fr = int'($floor((v - 1.0) * 16.0));
    return {s, 3'(e + 7), 4'(fr)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic hs;
    exp_t e;
    hs = 1'b0;
    @(negedge clk);
    chk("ready_mutex", {31'b0, req0_ready & req1_ready}, 0);
    chk("op_count", {16'b0, op_count}, exp_cnt & 32'hFFFF);
    chk("op_count4", {28'b0, op_count4}, exp_cnt & 32'hF);
    if (rst) begin
      chk("ready_in_rst", {30'b0, req0_ready, req1_ready}, 0);
    end else begin
      if (stall_prev && !rst_prev) begin
        chk("hold_valid", {31'b0, rsp_valid}, 1);
        chk("hold_data", {24'b0, rsp_data}, {24'b0, prev_data});
        chk("hold_id", {31'b0, rsp_id}, {31'b0, prev_id});
        chk("hold_no_ready", {31'b0, req0_ready | req1_ready}, 0);
      end
      if (req0_ready || req1_ready) begin
        e.id   = req1_ready;
        e.data = req1_ready ? f8mul(req1_a, req1_b) : f8mul(req0_a, req0_b);
        e.cyc  = cyc;
        sb.push_back(e);
        grants.push_back(int'(req1_ready));
        gcyc.push_back(cyc);
      end
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) chk("rsp_without_accept", 1, 0);
        else chk("latency", cyc, sb[0].cyc + 2);
      end
      if (rsp_valid && rsp_ready) begin
        hs = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
          chk("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
        end
      end
    end
    stall_prev = rsp_valid && !rsp_ready && !rst;
    prev_valid = rsp_valid && !rst;
    prev_data  = rsp_data;
    prev_id    = rsp_id;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_cnt = 0;
      sb.delete();
    end else if (hs) begin
      exp_cnt++;
    end
    rst_prev = rst;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    step();
    step();
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_data", {24'b0, rsp_data}, 0);
    chk("rst_rsp_id", {31'b0, rsp_id}, 0);
    chk("rst_op_count", {16'b0, op_count}, 0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Single request on requester 0
    req0_valid = 1'b1; req0_a = 8'h3A; req0_b = 8'h41;
    #1;
    chk("single_ready0", {31'b0, req0_ready}, 1);
    step();
    req0_valid = 1'b0; req0_a = 8'hFF; req0_b = 8'hFF;
    chk("single_calc_novalid", {31'b0, rsp_valid}, 0);
    step();
    chk("single_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("single_rsp_id", {31'b0, rsp_id}, 0);
    chk("single_rsp_data", {24'b0, rsp_data}, {24'b0, f8mul(8'h3A, 8'h41)});
    step();
    chk("single_count", {16'b0, op_count}, 1);
    step();

    // Contention after reset
    pulse_rst();
    grants.delete(); gcyc.delete();
    req0_valid = 1'b1; req0_a = 8'h49; req0_b = 8'h4E;
    req1_valid = 1'b1; req1_a = 8'h39; req1_b = 8'h3C;
    repeat (12) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();
    chk("cont_ngrants", grants.size(), 4);
    if (grants.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cont_order", grants[i], i % 2);
        if (i > 0) chk("cont_interval", gcyc[i] - gcyc[i-1], 3);
      end
    end

    // Backpressure with operand churn and a held competing request
    pulse_rst();
    req0_valid = 1'b1; req0_a = 8'hC2; req0_b = 8'h42;
    step();
    req0_valid = 1'b0; rsp_ready = 1'b0; req1_valid = 1'b1; req1_a = 8'h55; req1_b = 8'h33;
    step();
    cnt_snap = exp_cnt;
    for (int i = 0; i < 5; i++) begin
      req0_a = 8'(i * 17); req0_valid = 1'b1;
      #1;
      chk("bp_valid", {31'b0, rsp_valid}, 1);
      chk("bp_data", {24'b0, rsp_data}, {24'b0, f8mul(8'hC2, 8'h42)});
      chk("bp_readys", {30'b0, req0_ready, req1_ready}, 0);
      chk("bp_count", {16'b0, op_count}, cnt_snap);
      step();
    end
    req0_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk("bp_count_after", {16'b0, op_count}, cnt_snap + 1);
    #1;
    chk("bp_held_req1", {31'b0, req1_ready}, 1);
    step();
    req1_valid = 1'b0;
    repeat (3) step();

    // Reset while in CALC
    pulse_rst();
    req0_valid = 1'b1; req0_a = 8'h44; req0_b = 8'h45;
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", {31'b0, rsp_valid}, 0);
    chk("midrst_count", {16'b0, op_count}, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("midrst_grant0", {30'b0, req0_ready, req1_ready}, 2);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();
    step();
    chk("midrst_no_phantom", {16'b0, op_count}, 1);

    // Counter wrap on the 4-bit instance
    pulse_rst();
    req0_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      req0_a = 8'($urandom_range(0, 255));
      req0_b = 8'($urandom_range(0, 255));
      step();
    end
    req0_valid = 1'b0;
    chk("wrap_count16", {16'b0, op_count}, 16);
    chk("wrap_count4", {28'b0, op_count4}, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/float8_mul_arbiter.md
FLOAT8_MUL_ARBITER -- requirements
Module: float8_mul_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 presents an operand pair.
REQ-005 req0_a, req0_b  input  8 each  requester 0 operands, custom float8 format (sign bit 7, exponent bits 6:4 biased by 7, fraction bits 3:0 with implicit leading 1).
REQ-006 req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same directions, widths and meanings as REQ-004 to REQ-006, for requester 1.
REQ-008 rsp_valid  output  1  rsp_data and rsp_id are valid.
REQ-009 rsp_id  output  1  index of the requester that owns the response.
REQ-010 rsp_data  output  8  float8 product.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 op_count  output  CNT_W  number of completed responses.

Function
REQ-013 The block SHALL contain exactly one float8_multiplication instance, driven only from internal operand registers, and shared between both requesters.
REQ-014 FSM states SHALL be IDLE, CALC and RESP.
- IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready combinationally in the same cycle, latch its a/b and id, go to CALC; otherwise stay in IDLE.
- CALC: register the multiplier output into the result register, go to RESP.
- RESP: rsp_valid=1; on rsp_ready=1 go to IDLE and increment op_count; otherwise hold.
REQ-015 reqN_ready SHALL be high only in IDLE and only for the granted requester; both ready signals SHALL never be high together.
REQ-016 Arbitration SHALL be round-robin. With exactly one valid requester, that requester is granted. With both valid, the requester not granted last is granted. The last-grant pointer updates only on a grant.
REQ-017 Latency SHALL be fixed: a pair accepted in cycle N produces rsp_valid in cycle N+2.
REQ-018 The minimum issue interval SHALL be 3 cycles. If rsp_ready is high in RESP, the next grant is possible no earlier than the following cycle (one IDLE cycle).
REQ-019 rsp_data and rsp_id SHALL remain stable while rsp_valid=1 and rsp_ready=0, for any number of stall cycles.
REQ-020 Operands SHALL be captured only on a grant. Changes on req inputs after acceptance SHALL not affect the pending result.
REQ-021 Requester valid and operand inputs SHALL be ignored in CALC and RESP; a held reqN_valid is serviced on a later return to IDLE.
REQ-022 op_count SHALL wrap modulo 2^CNT_W with no saturation or flag.
REQ-023 rsp_data SHALL equal the float8_multiplication output for the latched operands bit-for-bit; this block applies no rounding, special-case or sign handling of its own.

Reset
REQ-024 With rst high at a clock edge, the block SHALL set:
- state IDLE;
- rsp_valid, req0_ready and req1_ready to 0;
- rsp_data to 8'h00 and rsp_id to 0;
- op_count to 0;
- the last-grant pointer to 1, so requester 0 wins the first contention.
REQ-025 Reset asserted in CALC or RESP SHALL discard the in-flight operation without producing a response or incrementing op_count.
REQ-026 reqN_ready SHALL be 0 in any cycle in which rst is high.

Verification
REQ-027 Single request: rsp_ready tied 1; req0_valid=1 with a=8'h3A, b=8'h41 for one cycle at N -> req0_ready=1 at N; rsp_valid=1, rsp_id=0 at N+2; rsp_data equals a standalone float8_multiplication(8'h3A,8'h41); op_count=1 at N+3.
REQ-028 Contention after reset: both valid continuously, req0 pairs (8'h49,8'h4E), req1 pairs (8'h39,8'h3C) -> grant order 0,1,0,1, rsp_id sequence 0,1,0,1, one grant every 3 cycles.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles in RESP with operands (8'hC2,8'h42) -> rsp_valid and rsp_data held for all 5 cycles; both readys 0; op_count unchanged until the accept cycle.
REQ-030 Reset mid-operation: rst pulsed in CALC -> next cycle rsp_valid=0, op_count=0, state IDLE; with both requesters valid, requester 0 is granted first.
REQ-031 Counter wrap: CNT_W=4, 16 completed operations -> op_count reads 0 after the 16th accept.
